// File: rtl/stream_extreme_tracker_if.sv
// Sample-stream and result-channel bundle for stream_extreme_tracker.
//
// Sample channel : in_valid, in_data[WIDTH], in_last (source -> tracker),
//                  in_ready (tracker -> source).
// Result channel : out_valid, out_value[WIDTH], out_index[IDX_W],
//                  out_count[IDX_W], out_all_eq, out_ovf (tracker -> consumer),
//                  out_ready (consumer -> tracker).
//
// modport slave  : the tracker's view.
// modport master : the view of the environment (sample source + consumer).
interface stream_extreme_tracker_if #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic [IDX_W-1:0] out_index;
    logic [IDX_W-1:0] out_count;
    logic             out_all_eq;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_value, out_index, out_count,
               out_all_eq, out_ovf
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_value, out_index, out_count,
               out_all_eq, out_ovf
    );
endinterface

// File: rtl/stream_extreme_tracker.sv
// Streaming max/min tracker. Scans one frame of WIDTH-bit samples and reports
// the extreme value, the beat index of its first occurrence, the saturating
// beat count, whether all beats were equal, and a count-overflow flag.
//
// Parameters:
//   WIDTH  - sample width (>= 1)
//   IDX_W  - width of index and count fields
//   SIGNED - 0: unsigned compare, 1: two's-complement compare
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   start  - begin a frame (honoured only in IDLE)
//   mode   - 0: maximum, 1: minimum; latched with start
//   busy   - high while a frame is in progress or its result is pending
//   bus    - sample stream in / result out (stream_extreme_tracker_if.slave)
module stream_extreme_tracker #(
    parameter int WIDTH  = 4,
    parameter int IDX_W  = 8,
    parameter int SIGNED = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic mode,
    output logic busy,
    stream_extreme_tracker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             mode_q;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] first_q;
    logic [IDX_W-1:0] index_q;
    logic [IDX_W-1:0] count_q;
    logic             all_eq_q;
    logic             ovf_q;

    logic             in_ready_d;
    logic             out_valid_d;
    logic             busy_d;

    logic             accept;
    logic             first_beat;
    logic             count_sat;
    logic             better;

    assign accept     = bus.in_valid && in_ready_d;
    // count is cleared on start and never wraps, so zero means no beat yet.
    assign first_beat = (count_q == '0);
    assign count_sat  = &count_q;

    // Strict compare so ties keep the earlier index.
    always_comb begin
        better = 1'b0;
        if (SIGNED != 0) begin
            if (mode_q) better = $signed(bus.in_data) < $signed(value_q);
            else        better = $signed(bus.in_data) > $signed(value_q);
        end else begin
            if (mode_q) better = bus.in_data < value_q;
            else        better = bus.in_data > value_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ACCUM;
            end
            ACCUM: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
                if (bus.in_valid && bus.in_last) state_next = DONE;
            end
            DONE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all datapath registers are reset, including first_q, so the
    // result fields read as defined zeros straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= 1'b0;
            value_q  <= '0;
            first_q  <= '0;
            index_q  <= '0;
            count_q  <= '0;
            all_eq_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        count_q  <= '0;
                        all_eq_q <= 1'b0;
                        ovf_q    <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (first_beat) begin
                            value_q  <= bus.in_data;
                            first_q  <= bus.in_data;
                            index_q  <= '0;
                            count_q  <= IDX_W'(1);
                            all_eq_q <= 1'b1;
                        end else begin
                            // count_q is the current beat number; once
                            // saturated it is all-ones, which is exactly the
                            // index reported for post-saturation extremes.
                            if (better) begin
                                value_q <= bus.in_data;
                                index_q <= count_q;
                            end
                            if (bus.in_data != first_q) all_eq_q <= 1'b0;
                            if (count_sat) ovf_q   <= 1'b1;
                            else           count_q <= count_q + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy           = busy_d;
    assign bus.in_ready   = in_ready_d;
    assign bus.out_valid  = out_valid_d;
    assign bus.out_value  = value_q;
    assign bus.out_index  = index_q;
    assign bus.out_count  = count_q;
    assign bus.out_all_eq = all_eq_q;
    assign bus.out_ovf    = ovf_q;

endmodule

// File: tb/tb_stream_extreme_tracker.sv
// Directed bench for stream_extreme_tracker. Three instances cover the
// parameter sets needed: unsigned/IDX_W=8, signed/IDX_W=8, unsigned/IDX_W=2.
// Sample and result handshake inputs are shared; each instance has its own
// start, and only one instance is active at a time. Observations are taken
// from the selected instance through a 32-bit mux.
module tb_stream_extreme_tracker;

    logic       clk;
    logic       rst;
    logic       mode;
    logic       start_a, start_b, start_c;
    logic       busy_a, busy_b, busy_c;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_ready;
    int         sel;

    int         vectors;
    int         errors;

    logic [31:0] obs_valid, obs_ready, obs_busy, obs_value, obs_index;
    logic [31:0] obs_count, obs_all_eq, obs_ovf;

    stream_extreme_tracker_if #(.WIDTH(4), .IDX_W(8)) bus_a ();
    stream_extreme_tracker_if #(.WIDTH(4), .IDX_W(8)) bus_b ();
    stream_extreme_tracker_if #(.WIDTH(4), .IDX_W(2)) bus_c ();

    stream_extreme_tracker #(.WIDTH(4), .IDX_W(8), .SIGNED(0)) u_max (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode), .busy(busy_a), .bus(bus_a)
    );
    stream_extreme_tracker #(.WIDTH(4), .IDX_W(8), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode), .busy(busy_b), .bus(bus_b)
    );
    stream_extreme_tracker #(.WIDTH(4), .IDX_W(2), .SIGNED(0)) u_ovf (
        .clk(clk), .rst(rst), .start(start_c), .mode(mode), .busy(busy_c), .bus(bus_c)
    );

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_data   = in_data;
    assign bus_a.in_last   = in_last;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_data   = in_data;
    assign bus_b.in_last   = in_last;
    assign bus_b.out_ready = out_ready;
    assign bus_c.in_valid  = in_valid;
    assign bus_c.in_data   = in_data;
    assign bus_c.in_last   = in_last;
    assign bus_c.out_ready = out_ready;

    always_comb begin
        obs_valid  = 32'(bus_a.out_valid);
        obs_ready  = 32'(bus_a.in_ready);
        obs_busy   = 32'(busy_a);
        obs_value  = 32'(bus_a.out_value);
        obs_index  = 32'(bus_a.out_index);
        obs_count  = 32'(bus_a.out_count);
        obs_all_eq = 32'(bus_a.out_all_eq);
        obs_ovf    = 32'(bus_a.out_ovf);
        if (sel == 1) begin
            obs_valid  = 32'(bus_b.out_valid);
            obs_ready  = 32'(bus_b.in_ready);
            obs_busy   = 32'(busy_b);
            obs_value  = 32'(bus_b.out_value);
            obs_index  = 32'(bus_b.out_index);
            obs_count  = 32'(bus_b.out_count);
            obs_all_eq = 32'(bus_b.out_all_eq);
            obs_ovf    = 32'(bus_b.out_ovf);
        end else if (sel == 2) begin
            obs_valid  = 32'(bus_c.out_valid);
            obs_ready  = 32'(bus_c.in_ready);
            obs_busy   = 32'(busy_c);
            obs_value  = 32'(bus_c.out_value);
            obs_index  = 32'(bus_c.out_index);
            obs_count  = 32'(bus_c.out_count);
            obs_all_eq = 32'(bus_c.out_all_eq);
            obs_ovf    = 32'(bus_c.out_ovf);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input int which, input logic m);
        sel     = which;
        mode    = m;
        start_a = (which == 0);
        start_b = (which == 1);
        start_c = (which == 2);
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic beat(input logic [3:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] v,
                                input logic [31:0] idx, input logic [31:0] cnt,
                                input logic [31:0] eq, input logic [31:0] ovf);
        check({tag, ".out_valid"},  obs_valid,  32'd1);
        check({tag, ".in_ready"},   obs_ready,  32'd0);
        check({tag, ".out_value"},  obs_value,  v);
        check({tag, ".out_index"},  obs_index,  idx);
        check({tag, ".out_count"},  obs_count,  cnt);
        check({tag, ".out_all_eq"}, obs_all_eq, eq);
        check({tag, ".out_ovf"},    obs_ovf,    ovf);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".out_valid"}, obs_valid, 32'd0);
        check({tag, ".busy"},      obs_busy,  32'd0);
        check({tag, ".in_ready"},  obs_ready, 32'd0);
    endtask

    initial begin
        vectors   = 0;
        errors    = 0;
        sel       = 0;
        rst       = 1'b1;
        mode      = 1'b0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        start_c   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_idle("reset");
        check("reset.out_value",  obs_value,  32'd0);
        check("reset.out_index",  obs_index,  32'd0);
        check("reset.out_count",  obs_count,  32'd0);
        check("reset.out_all_eq", obs_all_eq, 32'd0);
        check("reset.out_ovf",    obs_ovf,    32'd0);

        // Max unsigned: 3,9,(gap),2,9(last) -> 9 @1, count 4
        begin_frame(0, 1'b0);
        check("max.in_ready_after_start", obs_ready, 32'd1);
        check("max.busy_after_start",     obs_busy,  32'd1);
        beat(4'h3, 1'b0);
        beat(4'h9, 1'b0);
        step();
        check("max.gap_count_hold", obs_count, 32'd2);
        beat(4'h2, 1'b0);
        beat(4'h9, 1'b1);
        check_result("max", 32'h9, 32'd1, 32'd4, 32'd0, 32'd0);
        // start in the handshake cycle must be ignored
        out_ready = 1'b1;
        start_a   = 1'b1;
        step();
        out_ready = 1'b0;
        start_a   = 1'b0;
        check_idle("max.after_hs");
        check("max.idle_hold_value", obs_value, 32'h9);

        // Min signed: 2,E,7,E(last) -> E (-2) @1, count 4; mode toggled mid-frame
        begin_frame(1, 1'b1);
        mode = 1'b0;
        beat(4'h2, 1'b0);
        beat(4'hE, 1'b0);
        beat(4'h7, 1'b0);
        beat(4'hE, 1'b1);
        check_result("smin", 32'hE, 32'd1, 32'd4, 32'd0, 32'd0);
        handshake();
        check_idle("smin.after_hs");

        // All equal with backpressure: 5,5,5(last), out_ready low 3 cycles
        begin_frame(0, 1'b0);
        beat(4'h5, 1'b0);
        beat(4'h5, 1'b0);
        beat(4'h5, 1'b1);
        check_result("alleq", 32'h5, 32'd0, 32'd3, 32'd1, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_result("alleq.stall", 32'h5, 32'd0, 32'd3, 32'd1, 32'd0);
        end
        handshake();
        check_idle("alleq.after_hs");

        // Single beat: A(last); start during DONE ignored
        begin_frame(0, 1'b0);
        check("single.count_cleared", obs_count, 32'd0);
        beat(4'hA, 1'b1);
        check_result("single", 32'hA, 32'd0, 32'd1, 32'd1, 32'd0);
        mode    = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check_result("single.start_in_done", 32'hA, 32'd0, 32'd1, 32'd1, 32'd0);
        handshake();
        check_idle("single.after_hs");

        // Overflow, IDX_W=2: 1,1,1,1,8(last) -> count 3, ovf, 8 @3
        begin_frame(2, 1'b0);
        beat(4'h1, 1'b0);
        beat(4'h1, 1'b0);
        beat(4'h1, 1'b0);
        check("ovf.not_yet", obs_ovf, 32'd0);
        beat(4'h1, 1'b0);
        check("ovf.after_sat_beat", obs_ovf, 32'd1);
        beat(4'h8, 1'b1);
        check_result("ovf", 32'h8, 32'd3, 32'd3, 32'd0, 32'd1);
        handshake();
        check_idle("ovf.after_hs");

        // Reset mid-frame, then 4,6(last) -> 6 @1
        begin_frame(0, 1'b0);
        beat(4'h7, 1'b0);
        beat(4'h1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("midrst");
        check("midrst.out_value",  obs_value,  32'd0);
        check("midrst.out_index",  obs_index,  32'd0);
        check("midrst.out_count",  obs_count,  32'd0);
        check("midrst.out_all_eq", obs_all_eq, 32'd0);
        check("midrst.out_ovf",    obs_ovf,    32'd0);
        begin_frame(0, 1'b0);
        beat(4'h4, 1'b0);
        beat(4'h6, 1'b1);
        check_result("postrst", 32'h6, 32'd1, 32'd2, 32'd0, 32'd0);
        handshake();
        check_idle("postrst.after_hs");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/stream_extreme_tracker.md
# stream_extreme_tracker

Parametrised streaming comparator that scans a frame of WIDTH-bit samples and reports the maximum or minimum value, the index where it first occurred, the beat count, and whether every sample in the frame was equal. It succeeds the two-operand 4-bit max selector, which was purely combinational. This block adds a programmable width, max/min mode, signed mode, and an unbounded frame length. It sits between a sample source with valid/ready/last and a consumer that takes one result per frame.

## Interface
- WIDTH, 4: sample width in bits (≥1).
- IDX_W, 8: width of the index and count fields.
- SIGNED, 0: 0 compares unsigned; 1 compares two's-complement.

- clk  in  1  Rising-edge clock; the only clock.
- rst  in  1  Synchronous, active-high reset.
- start  in  1  Begins a frame; sampled only in IDLE.
- mode  in  1  0 selects maximum, 1 selects minimum. Latched on start.
- in_valid  in  1  Input sample valid.
- in_data  in  WIDTH  Input sample.
- in_last  in  1  Marks the final beat of the frame.
- in_ready  out  1  High only in ACCUM.
- out_valid  out  1  Result valid; held until accepted.
- out_ready  in  1  Consumer accepts the result.
- out_value  out  WIDTH  Extreme value of the frame.
- out_index  out  IDX_W  0-based beat index of the first occurrence of out_value.
- out_count  out  IDX_W  Number of accepted beats, saturating.
- out_all_eq  out  1  1 if every beat equalled beat 0.
- out_ovf  out  1  1 if the frame exceeded 2^IDX_W−1 beats.
- busy  out  1  High in ACCUM and DONE.

## Operation
- States: IDLE, ACCUM, DONE.
- **IDLE**
  - start=1 latches mode, clears count, all_eq and ovf, and moves to ACCUM.
  - mode is ignored without start.
- **ACCUM**
  - A beat is accepted when in_valid & in_ready.
  - First beat: loads value, sets index=0 and count=1, sets all_eq=1.
  - Later beats, max mode: replace the held value when in_data > value (strict).
  - Later beats, min mode: replace the held value when in_data < value (strict).
  - Ties keep the earlier index.
  - On replace, index takes the current beat number, which equals count before increment.
  - all_eq clears on any beat ≠ the first beat's data.
  - An accepted beat with in_last=1 moves to DONE; a frame of exactly one beat is legal.
- **DONE**
  - out_valid=1. Output fields are stable while out_valid & !out_ready.
  - out_valid & out_ready moves to IDLE.
- **Comparison:** SIGNED=1 uses $signed compares over the full WIDTH; SIGNED=0 uses unsigned compares.
- **Count saturation**
  - count saturates at 2^IDX_W−1.
  - Any accepted beat while count is saturated sets ovf.
  - Beats that arrive after saturation still update value and all_eq.
  - When such a beat becomes the new extreme, index is set to all-ones.
- **Ignored start:** start in ACCUM or DONE has no effect.
- **Reset**
  - rst in any state, including mid-frame, returns to IDLE next edge.
  - Reset values: out_valid=0, busy=0, in_ready=0, out_value=0, out_index=0, out_count=0, out_all_eq=0, out_ovf=0, latched mode=0.
  - Any partial frame is discarded.

## Timing
- in_ready and busy are registered-state decodes with no combinational path from in_valid.
- in_ready rises the cycle after start is sampled.
- Accepting the last beat on edge N gives out_valid=1 after edge N, so one cycle of latency; in_ready=0 from that cycle.
- The earliest next start is the cycle after the output handshake; start asserted in the handshake cycle is ignored.
- Throughput is one beat per cycle in ACCUM. in_valid gaps stall without side effects.
- out_* fields not being updated hold their last frame's value in IDLE. out_valid=0 in IDLE.

## Test plan
- **Max, unsigned:** WIDTH=4, mode=0, beats 3,9,2,9,last=1 → out_value=9, out_index=1, out_count=4, out_all_eq=0, out_valid one cycle after the last beat.
- **Min, signed:** SIGNED=1, mode=1, beats 0x2,0xE,0x7,0xE(last) → out_value=0xE (−2), out_index=1, out_count=4.
- **All equal with backpressure:** beats 5,5,5(last) with out_ready held 0 for 3 cycles → out_all_eq=1, out_index=0, outputs stable until the handshake, then IDLE.
- **Single beat:** one beat 0xA with in_last=1 → out_value=0xA, out_index=0, out_count=1, out_all_eq=1. A start asserted during DONE is ignored.
- **Overflow:** IDX_W=2, beats 1,1,1,1,8(last) → out_count=3, out_ovf=1, out_value=8, out_index=3.
- **Reset mid-frame:** two beats accepted, then rst=1 for one cycle → IDLE with all outputs at reset values. The next frame 4,6(last) gives out_value=6, out_index=1.
